pc_next_unit: RTL and testbench

- Program-counter and next-PC stage that consumes the branch-condition strobes (Con_beq/Con_bne/Con_blt/Con_bge) produced by the ALU controller.
- Resolves branch and jump outcomes against the register-file operands and holds the architectural PC register.
- Gates PC advance with a retire handshake and traps on misaligned control-flow targets.
- Maintains retired-instruction and taken-branch counters.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_next_unit_if.sv | 41 ++++
 rtl/branch_compare.sv | 28 ++
 rtl/pc_next_unit.sv | 103 ++++++++++
 tb/tb_pc_next_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / next-PC stage.
package pc_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned CNT_W_DEF    = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned PC_INC       = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_next_unit_if.sv
// Decode/operand inputs and PC/status outputs of the next-PC stage.
interface pc_next_unit_if
    import pc_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic             advance;
    logic             Con_beq;
    logic             Con_bne;
    logic             Con_blt;
    logic             Con_bge;
    logic             Jal;
    logic             Jalr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  PC;
    logic [XLEN-1:0]  PC_plus4;
    logic             pc_valid;
    logic             branch_taken;
    logic             misaligned;
    logic [CNT_W-1:0] retired_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output advance, Con_beq, Con_bne, Con_blt, Con_bge, Jal, Jalr,
        output rs1_data, rs2_data, imm,
        input  PC, PC_plus4, pc_valid, branch_taken, misaligned,
        input  retired_count, taken_count
    );

    modport slave (
        input  advance, Con_beq, Con_bne, Con_blt, Con_bge, Jal, Jalr,
        input  rs1_data, rs2_data, imm,
        output PC, PC_plus4, pc_valid, branch_taken, misaligned,
        output retired_count, taken_count
    );

endinterface

// File: rtl/branch_compare.sv
// Combinational branch-condition evaluation from the decoded Con_* strobes.
module branch_compare
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            con_beq_i,
    input  logic            con_bne_i,
    input  logic            con_blt_i,
    input  logic            con_bge_i,
    output logic            cond_o_c
);

    logic eq_c;
    logic lt_c;

    assign eq_c = (rs1_i == rs2_i);
    assign lt_c = ($signed(rs1_i) < $signed(rs2_i));

    // Strobes are OR-combined; simultaneous strobes are not an error.
    assign cond_o_c = (con_beq_i &  eq_c) |
                      (con_bne_i & ~eq_c) |
                      (con_blt_i &  lt_c) |
                      (con_bge_i & ~lt_c);

endmodule

// File: rtl/pc_next_unit.sv
// Architectural PC register with branch/jump resolution, retire gating,
// misaligned-target trap and retire/taken performance counters.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int unsigned     CNT_W    = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    pc_next_unit_if.slave bus
);

    pc_state_t        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             misaligned_q, misaligned_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic             cond_c;
    logic             taken_c;
    logic             misalign_c;
    logic [XLEN-1:0]  pc_plus4_c;
    logic [XLEN-1:0]  jalr_sum_c;
    logic [XLEN-1:0]  target_c;
    logic [XLEN-1:0]  next_pc_c;

    branch_compare #(.XLEN(XLEN)) u_branch_compare (
        .rs1_i     (bus.rs1_data),
        .rs2_i     (bus.rs2_data),
        .con_beq_i (bus.Con_beq),
        .con_bne_i (bus.Con_bne),
        .con_blt_i (bus.Con_blt),
        .con_bge_i (bus.Con_bge),
        .cond_o_c  (cond_c)
    );

    // Target and next-PC selection; Jalr overrides Jal, bit0 of the JALR sum is dropped.
    assign pc_plus4_c = pc_q + XLEN'(PC_INC);
    assign jalr_sum_c = bus.rs1_data + bus.imm;
    assign target_c   = bus.Jalr ? {jalr_sum_c[XLEN-1:1], 1'b0} : (pc_q + bus.imm);
    assign taken_c    = cond_c | bus.Jal | bus.Jalr;
    assign misalign_c = taken_c & (target_c[1:0] != 2'b00);
    assign next_pc_c  = taken_c ? target_c : pc_plus4_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            pc_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
            retired_q    <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            misaligned_q <= misaligned_d;
            retired_q    <= retired_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        retired_d    = retired_q;
        taken_cnt_d  = taken_cnt_q;

        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.advance) begin
                    // A misaligned redirect freezes the PC and counters until reset.
                    if (misalign_c) begin
                        state_d      = TRAP;
                        misaligned_d = 1'b1;
                    end else begin
                        pc_d        = next_pc_c;
                        retired_d   = retired_q + CNT_W'(1);
                        taken_cnt_d = taken_cnt_q + CNT_W'(taken_c);
                    end
                end
            end
            TRAP:    state_d = TRAP;
            default: state_d = BOOT;
        endcase

        pc_valid_d = (state_d == RUN);
    end

    assign bus.PC            = pc_q;
    assign bus.PC_plus4      = pc_plus4_c;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.branch_taken  = taken_c & pc_valid_q;
    assign bus.misaligned    = misaligned_q;
    assign bus.retired_count = retired_q;
    assign bus.taken_count   = taken_cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: per-cycle expectations queued at drive time.
module tb_pc_next_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 32;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b100000;
    localparam logic [5:0] BNE  = 6'b010000;
    localparam logic [5:0] BLT  = 6'b001000;
    localparam logic [5:0] BGE  = 6'b000100;
    localparam logic [5:0] JAL  = 6'b000010;
    localparam logic [5:0] JALR = 6'b000001;

    typedef struct packed {
        logic        rst;
        logic        adv;
        logic [5:0]  ctl;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] im;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic [31:0] ret;
        logic [31:0] tak;
    } snap_t;

    logic clk = 1'b0;
    logic reset;

    pc_next_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    pc_next_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    snap_t       exp_q[$];

    // Reference model: 0=BOOT 1=RUN 2=TRAP
    int          m_state = 0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_ret   = 32'h0;
    logic [31:0] m_tak   = 32'h0;
    logic        m_mis   = 1'b0;

    function automatic stim_t mk(input logic rst, input logic adv, input logic [5:0] ctl,
                                 input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
        mk = '{rst:rst, adv:adv, ctl:ctl, r1:r1, r2:r2, im:im};
    endfunction

    function automatic snap_t observe();
        observe = '{pc:bus.PC, pc4:bus.PC_plus4, valid:bus.pc_valid, mis:bus.misaligned,
                    ret:bus.retired_count, tak:bus.taken_count};
    endfunction

    // Drive one cycle, return observed/expected branch_taken, queue post-edge expectation.
    task automatic drive(input stim_t s, output logic bt_obs, output logic bt_exp);
        logic        cond, tk;
        logic [31:0] sum, tgt;
        @(negedge clk);
        reset        = s.rst;
        bus.advance  = s.adv;
        {bus.Con_beq, bus.Con_bne, bus.Con_blt, bus.Con_bge, bus.Jal, bus.Jalr} = s.ctl;
        bus.rs1_data = s.r1;
        bus.rs2_data = s.r2;
        bus.imm      = s.im;
        #1;
        bt_obs = bus.branch_taken;
        cond = (s.ctl[5] && (s.r1 == s.r2)) || (s.ctl[4] && (s.r1 != s.r2)) ||
               (s.ctl[3] && ($signed(s.r1) <  $signed(s.r2))) ||
               (s.ctl[2] && ($signed(s.r1) >= $signed(s.r2)));
        tk     = cond || s.ctl[1] || s.ctl[0];
        bt_exp = tk && (m_state == 1);
        sum    = s.r1 + s.im;
        tgt    = s.ctl[0] ? (sum & 32'hFFFF_FFFE) : (m_pc + s.im);
        if (s.rst) begin
            m_state = 0; m_pc = 32'h0; m_ret = 32'h0; m_tak = 32'h0; m_mis = 1'b0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1 && s.adv) begin
            if (tk && tgt[1:0] != 2'b00) begin
                m_state = 2; m_mis = 1'b1;
            end else begin
                m_pc  = tk ? tgt : (m_pc + 32'd4);
                m_ret = m_ret + 32'd1;
                if (tk) m_tak = m_tak + 32'd1;
            end
        end
        exp_q.push_back('{pc:m_pc, pc4:m_pc + 32'd4, valid:(m_state == 1), mis:m_mis,
                          ret:m_ret, tak:m_tak});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t tbl[$];
        logic  bo, be;
        snap_t e, o;
        tbl.push_back(mk(1, 1, NONE, 0, 0, 0));
        tbl.push_back(mk(0, 1, NONE, 0, 0, 0));
        tbl.push_back(mk(0, 1, NONE, 0, 0, 0));
        tbl.push_back(mk(0, 1, NONE, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i], bo, be);
            n_cmp++;
            if (bo !== be) begin n_bad++; $display("FAIL reset[%0d] branch_taken got %b want %b", i, bo, be); end
            e = exp_q.pop_front(); o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset[%0d] got pc=%h pc4=%h v=%b mis=%b ret=%0d tak=%0d want pc=%h pc4=%h v=%b mis=%b ret=%0d tak=%0d",
                         i, o.pc, o.pc4, o.valid, o.mis, o.ret, o.tak, e.pc, e.pc4, e.valid, e.mis, e.ret, e.tak);
            end
            if (i == 0) begin
                n_cmp++;
                if (bus.PC !== 32'h0 || bus.pc_valid !== 1'b0) begin
                    n_bad++; $display("FAIL reset_state got pc=%h v=%b want pc=00000000 v=0", bus.PC, bus.pc_valid);
                end
            end
        end
        n_cmp++;
        if (bus.PC !== 32'h8 || bus.retired_count !== 32'd2) begin
            n_bad++; $display("FAIL boot_steps got pc=%h ret=%0d want pc=00000008 ret=2", bus.PC, bus.retired_count);
        end
    endtask

    task automatic test_branch();
        stim_t tbl[$];
        logic  bo, be;
        snap_t e, o;
        tbl.push_back(mk(0, 1, JAL,  0,     0,     32'h8));
        tbl.push_back(mk(0, 1, BEQ,  5,     5,     32'h20));
        tbl.push_back(mk(0, 1, JALR, 32'h10, 0,    32'h0));
        tbl.push_back(mk(0, 1, BEQ,  5,     6,     32'h20));
        tbl.push_back(mk(0, 0, BNE,  5,     6,     32'h40));
        foreach (tbl[i]) begin
            drive(tbl[i], bo, be);
            n_cmp++;
            if (bo !== be) begin n_bad++; $display("FAIL branch[%0d] branch_taken got %b want %b", i, bo, be); end
            e = exp_q.pop_front(); o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL branch[%0d] got pc=%h ret=%0d tak=%0d v=%b mis=%b want pc=%h ret=%0d tak=%0d v=%b mis=%b",
                         i, o.pc, o.ret, o.tak, o.valid, o.mis, e.pc, e.ret, e.tak, e.valid, e.mis);
            end
            if (i == 1) begin
                n_cmp++;
                if (bus.PC !== 32'h30) begin n_bad++; $display("FAIL beq_taken pc got %h want 00000030", bus.PC); end
            end
            if (i == 3) begin
                n_cmp++;
                if (bus.PC !== 32'h14) begin n_bad++; $display("FAIL beq_not_taken pc got %h want 00000014", bus.PC); end
            end
        end
    endtask

    task automatic test_signed();
        stim_t tbl[$];
        logic  bo, be;
        snap_t e, o;
        tbl.push_back(mk(0, 1, BLT,       32'hFFFF_FFFF, 1,             32'h8));
        tbl.push_back(mk(0, 1, BGE,       32'hFFFF_FFFF, 1,             32'h8));
        tbl.push_back(mk(0, 1, BGE,       7,             7,             32'h10));
        tbl.push_back(mk(0, 1, BLT,       1,             32'hFFFF_FFFF, 32'h10));
        tbl.push_back(mk(0, 1, BEQ | BNE, 3,             4,             32'hC));
        tbl.push_back(mk(0, 1, BLT | BGE, 32'h8000_0000, 0,             32'h4));
        foreach (tbl[i]) begin
            drive(tbl[i], bo, be);
            n_cmp++;
            if (bo !== be) begin n_bad++; $display("FAIL signed[%0d] branch_taken got %b want %b", i, bo, be); end
            e = exp_q.pop_front(); o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL signed[%0d] got pc=%h ret=%0d tak=%0d want pc=%h ret=%0d tak=%0d",
                         i, o.pc, o.ret, o.tak, e.pc, e.ret, e.tak);
            end
        end
    endtask

    task automatic test_jalr();
        stim_t tbl[$];
        logic  bo, be;
        snap_t e, o;
        tbl.push_back(mk(0, 1, JALR,       32'h101, 0, 32'h4));
        tbl.push_back(mk(0, 1, JAL | JALR, 32'h200, 0, 32'h10));
        tbl.push_back(mk(0, 1, JALR,       32'h10,  0, 32'hFFFF_FFFC));
        foreach (tbl[i]) begin
            drive(tbl[i], bo, be);
            n_cmp++;
            if (bo !== be) begin n_bad++; $display("FAIL jalr[%0d] branch_taken got %b want %b", i, bo, be); end
            e = exp_q.pop_front(); o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL jalr[%0d] got pc=%h mis=%b v=%b want pc=%h mis=%b v=%b",
                         i, o.pc, o.mis, o.valid, e.pc, e.mis, e.valid);
            end
            if (i == 0) begin
                n_cmp++;
                if (bus.PC !== 32'h104 || bus.misaligned !== 1'b0) begin
                    n_bad++; $display("FAIL jalr_bit0 got pc=%h mis=%b want pc=00000104 mis=0", bus.PC, bus.misaligned);
                end
            end
            if (i == 1) begin
                n_cmp++;
                if (bus.PC !== 32'h210) begin n_bad++; $display("FAIL jal_jalr_prio pc got %h want 00000210", bus.PC); end
            end
        end
    endtask

    task automatic test_wrap();
        stim_t tbl[$];
        logic  bo, be;
        snap_t e, o;
        tbl.push_back(mk(0, 1, JALR, 32'hFFFF_FFFC, 0, 0));
        tbl.push_back(mk(0, 1, NONE, 0, 0, 0));
        tbl.push_back(mk(0, 1, NONE, 0, 0, 0));
        tbl.push_back(mk(1, 1, JAL,  0, 0, 32'h100));
        tbl.push_back(mk(0, 1, NONE, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i], bo, be);
            n_cmp++;
            if (bo !== be) begin n_bad++; $display("FAIL wrap[%0d] branch_taken got %b want %b", i, bo, be); end
            e = exp_q.pop_front(); o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL wrap[%0d] got pc=%h pc4=%h ret=%0d tak=%0d v=%b want pc=%h pc4=%h ret=%0d tak=%0d v=%b",
                         i, o.pc, o.pc4, o.ret, o.tak, o.valid, e.pc, e.pc4, e.ret, e.tak, e.valid);
            end
            if (i == 0) begin
                n_cmp++;
                if (bus.PC_plus4 !== 32'h0) begin n_bad++; $display("FAIL pc_plus4_wrap got %h want 00000000", bus.PC_plus4); end
            end
            if (i == 1) begin
                n_cmp++;
                if (bus.PC !== 32'h0) begin n_bad++; $display("FAIL pc_wrap got %h want 00000000", bus.PC); end
            end
            if (i == 3) begin
                n_cmp++;
                if (bus.PC !== 32'h0 || bus.retired_count !== 32'd0 || bus.taken_count !== 32'd0 || bus.pc_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_prio got pc=%h ret=%0d tak=%0d v=%b want pc=00000000 ret=0 tak=0 v=0",
                             bus.PC, bus.retired_count, bus.taken_count, bus.pc_valid);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        stim_t       tbl[$];
        logic        bo, be;
        snap_t       e, o;
        logic [31:0] ret_before, tak_before;
        ret_before = 32'h0;
        tak_before = 32'h0;
        tbl.push_back(mk(0, 1, JALR, 32'h40, 0, 0));
        tbl.push_back(mk(0, 1, JAL,  0,      0, 32'h6));
        tbl.push_back(mk(0, 1, JAL,  0,      0, 32'h8));
        tbl.push_back(mk(0, 1, NONE, 0,      0, 0));
        tbl.push_back(mk(1, 1, JAL,  0,      0, 32'h8));
        tbl.push_back(mk(0, 1, NONE, 0,      0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i], bo, be);
            n_cmp++;
            if (bo !== be) begin n_bad++; $display("FAIL misaligned[%0d] branch_taken got %b want %b", i, bo, be); end
            e = exp_q.pop_front(); o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL misaligned[%0d] got pc=%h mis=%b v=%b ret=%0d tak=%0d want pc=%h mis=%b v=%b ret=%0d tak=%0d",
                         i, o.pc, o.mis, o.valid, o.ret, o.tak, e.pc, e.mis, e.valid, e.ret, e.tak);
            end
            if (i == 0) begin
                ret_before = bus.retired_count;
                tak_before = bus.taken_count;
            end
            if (i == 1 || i == 3) begin
                n_cmp++;
                if (bus.PC !== 32'h40 || bus.misaligned !== 1'b1 || bus.pc_valid !== 1'b0 ||
                    bus.retired_count !== ret_before || bus.taken_count !== tak_before) begin
                    n_bad++;
                    $display("FAIL trap_hold[%0d] got pc=%h mis=%b v=%b ret=%0d tak=%0d want pc=00000040 mis=1 v=0 ret=%0d tak=%0d",
                             i, bus.PC, bus.misaligned, bus.pc_valid, bus.retired_count, bus.taken_count, ret_before, tak_before);
                end
            end
            if (i == 4) begin
                n_cmp++;
                if (bus.misaligned !== 1'b0 || bus.PC !== 32'h0 || bus.retired_count !== 32'd0) begin
                    n_bad++;
                    $display("FAIL trap_reset got mis=%b pc=%h ret=%0d want mis=0 pc=00000000 ret=0",
                             bus.misaligned, bus.PC, bus.retired_count);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t tbl[$];
        logic  bo, be;
        snap_t e, o;
        tbl.push_back(mk(1, 1, NONE, 0, 0, 0));
        tbl.push_back(mk(0, 1, NONE, 0, 0, 0));
        for (int k = 0; k < 60; k++) begin
            tbl.push_back(mk(1'b0, ($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)),
                             32'($urandom_range(0, 15) * 4 + $urandom_range(0, 1)) - 32'd16,
                             32'($urandom_range(0, 15) * 4) - 32'd16,
                             32'($urandom_range(0, 15) * 4) - 32'd32));
        end
        foreach (tbl[i]) begin
            drive(tbl[i], bo, be);
            n_cmp++;
            if (bo !== be) begin n_bad++; $display("FAIL b2b[%0d] branch_taken got %b want %b", i, bo, be); end
            e = exp_q.pop_front(); o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL b2b[%0d] got pc=%h pc4=%h v=%b mis=%b ret=%0d tak=%0d want pc=%h pc4=%h v=%b mis=%b ret=%0d tak=%0d",
                         i, o.pc, o.pc4, o.valid, o.mis, o.ret, o.tak, e.pc, e.pc4, e.valid, e.mis, e.ret, e.tak);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.advance  = 1'b0;
        bus.Con_beq  = 1'b0;
        bus.Con_bne  = 1'b0;
        bus.Con_blt  = 1'b0;
        bus.Con_bge  = 1'b0;
        bus.Jal      = 1'b0;
        bus.Jalr     = 1'b0;
        bus.rs1_data = 32'h0;
        bus.rs2_data = 32'h0;
        bus.imm      = 32'h0;

        test_reset();
        test_branch();
        test_signed();
        test_jalr();
        test_wrap();
        test_misaligned();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
